fifo_fwft_gen: RTL and testbench



---
 rtl/fifo_fwft_gen.sv | 97 +++++++++
 tb/tb_fifo_fwft_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_gen.sv
// fifo_fwft_gen: single-clock first-word-fall-through FIFO of any depth
// with occupancy, almost-full/empty thresholds and sticky error flags.
module fifo_fwft_gen #(
  parameter int width    = 16,
  parameter int depth    = 4096,
  parameter int af_level = depth - 2,
  parameter int ae_level = 2,
  localparam int CW = $clog2(depth + 1),
  localparam int AW = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic             clk,
  input  logic             ap_rst_n,
  input  logic [width-1:0] din,
  input  logic             write,
  output logic             full_n,
  output logic             almost_full,
  output logic [width-1:0] dout,
  input  logic             read,
  output logic             empty_n,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  logic [width-1:0] mem_q [depth];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_n_q, full_n_d;
  logic          empty_n_q, empty_n_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc, rd_acc;

  always_comb begin
    wr_acc   = write & full_n_q;
    rd_acc   = read & empty_n_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc)
      wr_ptr_d = (wr_ptr_q == AW'(depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (rd_acc)
      rd_ptr_d = (rd_ptr_q == AW'(depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // flags are registered from the next occupancy
    full_n_d  = (count_d != CW'(depth));
    empty_n_d = (count_d != '0);
    af_d      = (count_d >= CW'(af_level));
    ae_d      = (count_d <= CW'(ae_level));
    ovf_d     = ovf_q | (write & ~full_n_q);
    unf_d     = unf_q | (read & ~empty_n_q);
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      if (wr_acc) mem_q[wr_ptr_q] <= din;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign dout         = mem_q[rd_ptr_q];
  assign full_n       = full_n_q;
  assign empty_n      = empty_n_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_fwft_gen.sv
// tb_fifo_fwft_gen: vector table plus data scoreboard for fifo_fwft_gen
// at width=8, depth=5, af_level=4, ae_level=1.
module tb_fifo_fwft_gen;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic [W-1:0]  din = '0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic          full_n, almost_full, empty_n, almost_empty;
  logic          overflow, underflow;
  logic [W-1:0]  dout;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] sbq [$];

  fifo_fwft_gen #(.width(W), .depth(D), .af_level(4), .ae_level(1)) dut (
    .clk(clk), .ap_rst_n(ap_rst_n), .din(din), .write(write),
    .full_n(full_n), .almost_full(almost_full), .dout(dout),
    .read(read), .empty_n(empty_n), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] d;
    int         cnt;
    logic       fn;
    logic       en;
    logic       af;
    logic       ae;
    logic       ov;
    logic       un;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // one clock with the given request; scoreboard tracks accepted words
  task automatic step(input logic wr, input logic rd, input logic [7:0] d);
    bit wa, ra;
    wa = wr && (sbq.size() < D);
    ra = rd && (sbq.size() > 0);
    write = wr;
    read  = rd;
    din   = d;
    @(posedge clk);
    #1;
    if (ra) void'(sbq.pop_front());
    if (wa) sbq.push_back(d);
    write = 1'b0;
    read  = 1'b0;
    if (sbq.size() > 0) chk("dout", int'(dout), int'(sbq[0]));
  endtask

  task automatic chk_state(input string nm);
    chk({nm, ".count"}, int'(count), sbq.size());
    chk({nm, ".empty_n"}, int'(empty_n), int'(sbq.size() != 0));
    chk({nm, ".full_n"}, int'(full_n), int'(sbq.size() != D));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".count"}, int'(count), 0);
    chk({nm, ".full_n"}, int'(full_n), 1);
    chk({nm, ".empty_n"}, int'(empty_n), 0);
    chk({nm, ".ae"}, int'(almost_empty), 1);
    chk({nm, ".af"}, int'(almost_full), 0);
    chk({nm, ".ovf"}, int'(overflow), 0);
    chk({nm, ".unf"}, int'(underflow), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          wr    rd    din   cnt fn    en    af    ae    ov    un
    vt[0]  = '{1'b1, 1'b0, 8'h11, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 8'h22, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 8'h33, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 8'h44, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 8'h55, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 8'h66, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 8'h00, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 8'h00, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 8'h00, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 8'h00, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b1, 8'h00, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    #12;
    chk_reset("rst_hold");
    #10;
    ap_rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("idle");

    // fill, overflow attempt, drain
    for (int i = 0; i < 12; i++) begin
      step(vt[i].wr, vt[i].rd, vt[i].d);
      chk($sformatf("v%0d.count", i), int'(count), vt[i].cnt);
      chk($sformatf("v%0d.full_n", i), int'(full_n), int'(vt[i].fn));
      chk($sformatf("v%0d.empty_n", i), int'(empty_n), int'(vt[i].en));
      chk($sformatf("v%0d.af", i), int'(almost_full), int'(vt[i].af));
      chk($sformatf("v%0d.ae", i), int'(almost_empty), int'(vt[i].ae));
      chk($sformatf("v%0d.ovf", i), int'(overflow), int'(vt[i].ov));
      chk($sformatf("v%0d.unf", i), int'(underflow), int'(vt[i].un));
    end

    // wrap-around with simultaneous write and read at count=2
    step(1'b1, 1'b0, 8'h01);
    step(1'b1, 1'b0, 8'h02);
    chk_state("pre_wrap");
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 8'(8'hA0 + i));
      chk($sformatf("wrap%0d.count", i), int'(count), 2);
    end
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    chk_state("drained");

    // write and read together while empty: no pass-through
    chk("pre_unf", int'(underflow), 0);
    step(1'b1, 1'b1, 8'h5A);
    chk("empty_rw.count", int'(count), 1);
    chk("empty_rw.unf", int'(underflow), 1);
    chk("empty_rw.dout", int'(dout), 8'h5A);
    step(1'b0, 1'b0, 8'h00);
    chk("unf_sticky", int'(underflow), 1);

    // asynchronous reset mid-stream at count=3
    step(1'b1, 1'b0, 8'h61);
    step(1'b1, 1'b0, 8'h62);
    chk_state("pre_rst");
    #3;
    ap_rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    sbq.delete();
    #2;
    ap_rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h77);
    chk("post_rst.count", int'(count), 1);
    chk("post_rst.empty_n", int'(empty_n), 1);
    chk("post_rst.dout", int'(dout), 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
